// File: rtl/spi_arb_pkg.sv
// Shared helpers for the SPI minion composites: address-field extraction and
// insertion on a message word, plus the drop-counter width.
package spi_arb_pkg;

  localparam int DROP_CNT_NBITS = 8;
  localparam int MAX_MSG_NBITS  = 64;
  localparam int MAX_ADDR_NBITS = 3;

  // Fields sit at msg[msg_nbits-1 -: addr_nbits]; callers cast to their own widths.
  function automatic logic [MAX_ADDR_NBITS-1:0] get_addr(
    input logic [MAX_MSG_NBITS-1:0] msg,
    input int                       msg_nbits,
    input int                       addr_nbits
  );
    return MAX_ADDR_NBITS'((msg >> (msg_nbits - addr_nbits)) &
                           ((MAX_MSG_NBITS'(1) << addr_nbits) - 1));
  endfunction

  function automatic logic [MAX_MSG_NBITS-1:0] set_addr(
    input logic [MAX_MSG_NBITS-1:0]  msg,
    input logic [MAX_ADDR_NBITS-1:0] addr,
    input int                        msg_nbits,
    input int                        addr_nbits
  );
    logic [MAX_MSG_NBITS-1:0] mask;
    mask = ((MAX_MSG_NBITS'(1) << addr_nbits) - 1) << (msg_nbits - addr_nbits);
    return (msg & ~mask) | ((MAX_MSG_NBITS'(addr) << (msg_nbits - addr_nbits)) & mask);
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning upward from prio; prio moves just
// past the winner whenever en is high and a grant is issued.
module spi_rr_arbiter #(
  parameter int num_ports = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [num_ports-1:0] req,
  output logic [num_ports-1:0] grant
);

  localparam int idx_nbits = $clog2(num_ports);

  logic [idx_nbits-1:0] prio;
  logic [idx_nbits-1:0] grant_idx;
  logic [idx_nbits-1:0] idx;

  // Scan from farthest to nearest so the port closest to prio overwrites the rest.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    for (int k = num_ports - 1; k >= 0; k--) begin
      idx = idx_nbits'((int'(prio) + k) % num_ports);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio <= '0;
    end else if (en && (|grant)) begin
      prio <= idx_nbits'((int'(grant_idx) + 1) % num_ports);
    end
  end

endmodule

// File: rtl/spi_minion_arb_router.sv
// Shares the SPI minion adapter's val/rdy channel among num_ports requesters:
// tagged round-robin arbitration outbound, address-decoded routing inbound.
module spi_minion_arb_router
  import spi_arb_pkg::*;
#(
  parameter  int msg_nbits  = 32,
  parameter  int num_ports  = 4,
  localparam int addr_nbits = $clog2(num_ports),
  localparam int data_nbits = msg_nbits - addr_nbits
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [msg_nbits-1:0]            up_recv_msg,
  input  logic                            up_recv_val,
  output logic                            up_recv_rdy,
  output logic [msg_nbits-1:0]            up_send_msg,
  output logic                            up_send_val,
  input  logic                            up_send_rdy,
  input  logic [num_ports*data_nbits-1:0] req_msg,
  input  logic [num_ports-1:0]            req_val,
  output logic [num_ports-1:0]            req_rdy,
  output logic [num_ports*data_nbits-1:0] resp_msg,
  output logic [num_ports-1:0]            resp_val,
  input  logic [num_ports-1:0]            resp_rdy,
  output logic [DROP_CNT_NBITS-1:0]       drop_count
);

  logic                  can_accept;
  logic [num_ports-1:0]  arb_req;
  logic [num_ports-1:0]  grant;
  logic [data_nbits-1:0] sel_data;
  logic [addr_nbits-1:0] sel_idx;
  logic                  out_full;
  logic [msg_nbits-1:0]  out_msg;

  // Reset gates the requests so no requester sees rdy while the block is held.
  assign can_accept = !reset && (!out_full || up_send_rdy);
  assign arb_req    = req_val & {num_ports{can_accept}};
  assign req_rdy    = grant;

  spi_rr_arbiter #(.num_ports(num_ports)) arb (
    .clk   (clk),
    .reset (reset),
    .en    (can_accept),
    .req   (arb_req),
    .grant (grant)
  );

  always_comb begin
    sel_data = '0;
    sel_idx  = '0;
    for (int i = 0; i < num_ports; i++) begin
      if (grant[i]) begin
        sel_data = req_msg[i*data_nbits +: data_nbits];
        sel_idx  = addr_nbits'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_full <= 1'b0;
      out_msg  <= '0;
    end else if (|grant) begin
      out_full <= 1'b1;
      out_msg  <= msg_nbits'(set_addr(MAX_MSG_NBITS'(sel_data), MAX_ADDR_NBITS'(sel_idx),
                                      msg_nbits, addr_nbits));
    end else if (up_send_rdy) begin
      out_full <= 1'b0;
    end
  end

  assign up_send_val = out_full;
  assign up_send_msg = out_msg;

  logic                  in_full;
  logic [msg_nbits-1:0]  in_msg;
  logic [addr_nbits-1:0] in_addr;
  logic                  in_valid;
  logic                  deliver;
  logic                  in_leave;

  assign in_addr  = addr_nbits'(get_addr(MAX_MSG_NBITS'(in_msg), msg_nbits, addr_nbits));
  assign in_valid = int'(in_addr) < num_ports;

  always_comb begin
    resp_val = '0;
    resp_msg = '0;
    deliver  = 1'b0;
    for (int i = 0; i < num_ports; i++) begin
      if (in_full && in_addr == addr_nbits'(i)) begin
        resp_val[i]                            = 1'b1;
        resp_msg[i*data_nbits +: data_nbits]   = in_msg[data_nbits-1:0];
        deliver                                = resp_rdy[i];
      end
    end
  end

  // An out-of-range entry leaves unconditionally, one cycle after it was loaded.
  assign in_leave    = in_full && (!in_valid || deliver);
  assign up_recv_rdy = !in_full || in_leave;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_full    <= 1'b0;
      in_msg     <= '0;
      drop_count <= '0;
    end else begin
      if (up_recv_val && up_recv_rdy) begin
        in_full <= 1'b1;
        in_msg  <= up_recv_msg;
      end else if (in_leave) begin
        in_full <= 1'b0;
      end
      if (in_full && !in_valid && drop_count != '1) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/spi_minion_arb_router.md
# spi_minion_arb_router

Multiplexes the SPI minion adapter's single val/rdy message channel among `num_ports` on-chip requesters. Outbound traffic (requester → SPI master): requests arbitrate round-robin, are tagged with the source port index, and are buffered into the adapter's receive port. Inbound traffic (SPI master → chip): messages from the adapter's send port are buffered, decoded by an address field, and delivered to the addressed requester's response port. Sits directly between the minion adapter and the chip-side accelerators and memory ports.

## Interface
- `msg_nbits`, 32: adapter payload width; equals the adapter's `nbits-2`.
- `num_ports`, 4: number of requester/responder ports, range 2..8.
- `addr_nbits`, derived `$clog2(num_ports)`: width of the address field, `msg[msg_nbits-1 -: addr_nbits]`.
- `data_nbits`, derived `msg_nbits-addr_nbits`: requester data width, `msg[data_nbits-1:0]`.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high.
- `up_recv_msg`, in, `msg_nbits`: message from the adapter send port.
- `up_recv_val`, in, 1, and `up_recv_rdy`, out, 1: handshake for `up_recv_msg`.
- `up_send_msg`, out, `msg_nbits`: message to the adapter receive port.
- `up_send_val`, out, 1, and `up_send_rdy`, in, 1: handshake for `up_send_msg`.
- `req_msg`, in, `num_ports*data_nbits`: flattened requester data; port i occupies slice i.
- `req_val`, in, `num_ports`, and `req_rdy`, out, `num_ports`: requester handshakes.
- `resp_msg`, out, `num_ports*data_nbits`: flattened response data.
- `resp_val`, out, `num_ports`, and `resp_rdy`, in, `num_ports`: response handshakes.
- `drop_count`, out, 8: saturating count of inbound messages with an invalid address.

## Operation
- **Transfer rule.** A transfer occurs on a rising edge where val and rdy are both high. `val` never depends combinationally on `rdy`.
- **Outbound arbiter.**
  - Round-robin over ports whose `req_val` is high, starting at pointer `prio`.
  - The grant is one-hot and asserted only when the out-buffer can accept: the buffer is empty, or `up_send_rdy` is high this cycle.
  - `req_rdy[i]` = grant[i]. At most one requester is accepted per cycle.
- **Outbound buffer.** One entry.
  - On grant i it loads `{i[addr_nbits-1:0], req_msg slice i}`.
  - `up_send_val` = buffer full. `up_send_msg` = buffer contents.
- **Priority pointer.** On an accepted grant i, `prio` becomes (i+1) mod `num_ports`. With no grant, `prio` holds.
- **Inbound buffer.** One entry.
  - `up_recv_rdy` = buffer empty, or the current entry is leaving this cycle.
  - Leaving means: delivered on `resp` (`resp_rdy` of the addressed port high), or being dropped.
- **Router.**
  - Let a = address field of the buffered entry.
  - If a < `num_ports`: `resp_val[a]` = 1 and `resp_msg` slice a = data field. All other `resp_val` bits are 0. Unaddressed data slices are driven to 0.
  - If a ≥ `num_ports` (only possible when `num_ports` is not a power of 2): the entry is discarded one cycle after loading, with no `resp_val`, and `drop_count` increments.
  - `drop_count` saturates at 255.
- **Reset values** (all taken asynchronously): buffers empty, `prio`=0, `drop_count`=0. Hence `up_send_val`=0, `resp_val`=0, `up_recv_rdy`=1, `up_send_msg`=0, `resp_msg`=0.
  - All `req_rdy` are 0 while `reset` is high.
  - A reset during a transfer discards both buffers. No partially transferred message survives.

## Timing
- **Latency:** `req` accept → `up_send_val` is 1 cycle. `up_recv` accept → `resp_val` is 1 cycle.
- **Throughput:** 1 message/cycle in each direction when downstream is always ready (pipe behaviour). The two directions are fully independent.
- **Simultaneous drain and refill:** allowed in the same cycle in both buffers.
- **Backpressure:** with `up_send_rdy` low and the buffer full, all `req_rdy` are 0 and `prio` holds.
- **Fairness:** a continuously valid requester is granted within `num_ports` accepted transfers.
- **Combinational paths:**
  - `req_rdy` depends combinationally on `req_val`, `prio`, out-buffer state and `up_send_rdy`.
  - `up_recv_rdy` depends combinationally on `resp_rdy`.
  - There are no paths from `req_val` to `up_send_val` or from `up_recv_val` to `resp_val`.

## Structure
- **Shared package `spi_arb_pkg`:**
  - address-field extraction and insertion functions (parameterised by `msg_nbits`/`addr_nbits`);
  - the `DROP_CNT_NBITS`=8 constant.
- **Sub-module `spi_rr_arbiter`:** `num_ports` requests in; one-hot grant out; `en` input advances `prio`; asynchronous reset. It is reusable by other SPI composites.
- **Buffers:** both one-entry buffers and the router decode stay inline in this block.

## Test plan
- **Single requester:** `num_ports`=4; port 2 sends data 0x0ABCDEF with `up_send_rdy`=1 → next cycle `up_send_val`=1, `up_send_msg`={2'd2, 0x0ABCDEF}.
- **Round-robin fairness:** all four `req_val` held high, `up_send_rdy`=1 for 8 cycles → grant order 0,1,2,3,0,1,2,3 with one message per cycle.
- **Backpressure:** buffer full and `up_send_rdy`=0 for 5 cycles → `req_rdy`=0 throughout, `up_send_msg` stable. Then `up_send_rdy`=1 → drain and refill in the same cycle.
- **Inbound routing:** `up_recv_msg`={2'd3, 0x1234}, `resp_rdy[3]`=0 for 3 cycles → `resp_val[3]`=1 held, `up_recv_rdy`=0. Then `resp_rdy[3]`=1 → delivered and `up_recv_rdy`=1 in the same cycle.
- **Invalid address:** `num_ports`=3, inbound address 3 ×300 → no `resp_val`, `drop_count`=255 (saturated).
- **Asynchronous reset:** reset asserted mid-stream with both buffers full → `up_send_val`, `resp_val` and `drop_count` go to 0 before the next clock edge; after release, port 0 has first priority.
